// File: rtl/fpu_pkg.sv
// Shared types and constants for the FP32 issue controller.
package fpu_pkg;

  // Default timing of the attached execution units.
  localparam int MUL_LAT_DEF     = 3;
  localparam int ADD_LAT_DEF     = 2;
  localparam int DIV_TIMEOUT_DEF = 64;
  localparam int CNT_W_DEF       = 7;

  // Unit mode encoding driven onto fpu_mode.
  typedef enum logic [2:0] {
    MODE_MUL  = 3'b000,
    MODE_ADD  = 3'b001,
    MODE_SUB  = 3'b010,
    MODE_DIV  = 3'b011,
    MODE_NONE = 3'b111
  } fpu_mode_t;

  // Writeback status codes.
  typedef enum logic [1:0] {
    EXC_OK          = 2'b00,
    EXC_ILLEGAL     = 2'b01,
    EXC_DIV_TIMEOUT = 2'b10
  } fpu_exc_t;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } fpu_state_t;

  localparam logic [6:0] OPCODE_OP_FP  = 7'b1010011;
  localparam logic [6:0] FUNCT7_FADD   = 7'b0000000;
  localparam logic [6:0] FUNCT7_FSUB   = 7'b0000100;
  localparam logic [6:0] FUNCT7_FMUL   = 7'b0001000;
  localparam logic [6:0] FUNCT7_FDIV   = 7'b0001100;
  localparam logic [5:0] DIV_DONE_FLAG = 6'd15;

endpackage

// File: rtl/fpu_instr_decode.sv
// Combinational OP-FP decoder: instruction word to unit mode, rd and illegal flag.
module fpu_instr_decode
  import fpu_pkg::*;
(
  input  logic [31:0] instr,
  output fpu_mode_t   mode,
  output logic [4:0]  rd,
  output logic        illegal
);

  // Register-source and rounding-mode fields play no part in unit selection.
  logic unused_fields;
  assign unused_fields = ^instr[24:12];

  assign rd = instr[11:7];

  // Map funct7 onto a unit mode; anything unrecognised or off-opcode is illegal.
  always_comb begin
    mode    = MODE_NONE;
    illegal = 1'b1;
    if (instr[6:0] == OPCODE_OP_FP) begin
      illegal = 1'b0;
      case (instr[31:25])
        FUNCT7_FADD: mode = MODE_ADD;
        FUNCT7_FSUB: mode = MODE_SUB;
        FUNCT7_FMUL: mode = MODE_MUL;
        FUNCT7_FDIV: mode = MODE_DIV;
        default:     illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Single-issue front end for the FP32 unit: accept, hold operands, capture, write back.
module fpu_issue_ctrl
  import fpu_pkg::*;
#(
  parameter int MUL_LAT     = MUL_LAT_DEF,
  parameter int ADD_LAT     = ADD_LAT_DEF,
  parameter int DIV_TIMEOUT = DIV_TIMEOUT_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  output logic [2:0]  fpu_mode,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  input  logic [31:0] fpu_result,
  input  logic [5:0]  fpu_div_flag,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_rd,
  output logic [31:0] out_data,
  output logic [1:0]  out_exc
);

  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] ADD_LAST = CNT_W'(ADD_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_TIMEOUT - 1);

  fpu_state_t       state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  fpu_mode_t        mode_q;
  logic [31:0]      a_q, b_q, data_q;
  logic [4:0]       rd_q;
  fpu_exc_t         exc_q;

  fpu_mode_t        dec_mode;
  logic [4:0]       dec_rd;
  logic             dec_illegal;

  logic             accept;
  logic             finish_ok;
  logic             finish_timeout;

  fpu_instr_decode u_decode (
    .instr   (instr),
    .mode    (dec_mode),
    .rd      (dec_rd),
    .illegal (dec_illegal)
  );

  // Next-state, completion detection and handshake outputs; mode is forced to NONE outside EXEC.
  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    accept         = 1'b0;
    finish_ok      = 1'b0;
    finish_timeout = 1'b0;
    in_ready       = 1'b0;
    out_valid      = 1'b0;
    fpu_mode       = MODE_NONE;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept     = 1'b1;
          cnt_next   = '0;
          state_next = dec_illegal ? ST_DONE : ST_EXEC;
        end
      end
      ST_EXEC: begin
        fpu_mode = mode_q;
        cnt_next = cnt + 1'b1;
        case (mode_q)
          MODE_MUL: finish_ok = (cnt == MUL_LAST);
          MODE_ADD,
          MODE_SUB: finish_ok = (cnt == ADD_LAST);
          MODE_DIV: begin
            if ((cnt != '0) && (fpu_div_flag == DIV_DONE_FLAG)) begin
              finish_ok = 1'b1;
            end else if (cnt == DIV_LAST) begin
              finish_timeout = 1'b1;
            end
          end
          default: finish_ok = 1'b1;
        endcase
        if (finish_ok || finish_timeout) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State, counter, operand holding and result capture registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      mode_q <= MODE_NONE;
      a_q    <= '0;
      b_q    <= '0;
      rd_q   <= '0;
      data_q <= '0;
      exc_q  <= EXC_OK;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (accept) begin
        rd_q <= dec_rd;
        if (dec_illegal) begin
          mode_q <= MODE_NONE;
          data_q <= '0;
          exc_q  <= EXC_ILLEGAL;
        end else begin
          mode_q <= dec_mode;
          a_q    <= rs1_val;
          b_q    <= rs2_val;
        end
      end
      if (finish_ok) begin
        data_q <= fpu_result;
        exc_q  <= EXC_OK;
      end else if (finish_timeout) begin
        data_q <= '0;
        exc_q  <= EXC_DIV_TIMEOUT;
      end
    end
  end

  assign fpu_a    = a_q;
  assign fpu_b    = b_q;
  assign out_rd   = rd_q;
  assign out_data = data_q;
  assign out_exc  = exc_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Self-checking bench for fpu_issue_ctrl against a transaction-level reference model.
module tb_fpu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [2:0]  fpu_mode;
  logic [31:0] fpu_a;
  logic [31:0] fpu_b;
  logic [31:0] fpu_result;
  logic [5:0]  fpu_div_flag;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_rd;
  logic [31:0] out_data;
  logic [1:0]  out_exc;

  int total = 0;
  int bad   = 0;

  fpu_issue_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .instr        (instr),
    .rs1_val      (rs1_val),
    .rs2_val      (rs2_val),
    .fpu_mode     (fpu_mode),
    .fpu_a        (fpu_a),
    .fpu_b        (fpu_b),
    .fpu_result   (fpu_result),
    .fpu_div_flag (fpu_div_flag),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_rd       (out_rd),
    .out_data     (out_data),
    .out_exc      (out_exc)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Hard stop in case something wedges outside the bounded waits.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mkInstr(input logic [6:0] f7, input logic [4:0] rd, input logic [6:0] op);
    logic [31:0] w;
    w = {f7, 5'd2, 5'd1, 3'b000, rd, op};
    return w;
  endfunction

  // Reference model: what a transaction should produce, straight from the instruction table.
  // flag_cyc is the EXEC cycle (1 = first) on which the divider raises its done flag, 0 = never.
  task automatic refModel(input logic [31:0] ins, input int flag_cyc,
                          output logic [2:0] mode, output int lat,
                          output logic [1:0] exc, output bit legal);
    legal = (ins[6:0] == 7'b1010011);
    mode  = 3'b111;
    lat   = 1;
    exc   = 2'b01;
    if (legal) begin
      case (ins[31:25])
        7'b0000000: begin mode = 3'b001; lat = 2 + 1; end
        7'b0000100: begin mode = 3'b010; lat = 2 + 1; end
        7'b0001000: begin mode = 3'b000; lat = 3 + 1; end
        7'b0001100: begin
          mode = 3'b011;
          lat  = (flag_cyc >= 2 && flag_cyc <= 64) ? flag_cyc + 1 : 64 + 1;
        end
        default: legal = 1'b0;
      endcase
    end
    if (legal) begin
      exc = (mode == 3'b011 && lat == 65 && !(flag_cyc == 64)) ? 2'b10 : 2'b00;
    end
  endtask

  // One full transaction: offer, emulate the unit, check writeback, optionally stall the consumer.
  task automatic applyStimulus(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] res, input int flag_cyc, input int stall);
    logic [2:0]  emode;
    logic [1:0]  eexc;
    logic [31:0] edata;
    int          elat;
    int          cyc;
    bit          legal;
    logic [5:0]  fl;
    refModel(ins, flag_cyc, emode, elat, eexc, legal);
    edata = (eexc == 2'b00) ? res : 32'h0;

    checkOutput("idle_in_ready", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1;
    instr    = ins;
    rs1_val  = a;
    rs2_val  = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    instr    = $urandom;
    rs1_val  = $urandom;
    rs2_val  = $urandom;

    cyc = 1;
    while (!out_valid && cyc <= 100) begin
      checkOutput("exec_mode", {29'b0, fpu_mode}, {29'b0, emode});
      checkOutput("exec_a", fpu_a, a);
      checkOutput("exec_b", fpu_b, b);
      checkOutput("exec_in_ready", {31'b0, in_ready}, 32'd0);
      fpu_result = (cyc == elat - 1) ? res : $urandom;
      if (emode == 3'b011) begin
        fl = 6'($urandom_range(0, 62));
        if (fl >= 6'd15) fl = fl + 6'd1;
        fpu_div_flag = (cyc == flag_cyc) ? 6'd15 : fl;
      end else begin
        fpu_div_flag = 6'($urandom_range(0, 63));
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (cyc > 100) begin
      checkOutput("wait_out_valid", 32'd0, 32'd1);
      return;
    end

    checkOutput("latency", cyc, elat);
    checkOutput("out_data", out_data, edata);
    checkOutput("out_exc", {30'b0, out_exc}, {30'b0, eexc});
    if (legal) checkOutput("out_rd", {27'b0, out_rd}, {27'b0, ins[11:7]});
    checkOutput("done_mode", {29'b0, fpu_mode}, 32'd7);
    checkOutput("done_in_ready", {31'b0, in_ready}, 32'd0);

    for (int s = 0; s < stall; s++) begin
      in_valid  = 1'b1;
      instr     = mkInstr(7'b0001000, 5'd3, 7'b1010011);
      out_ready = 1'b0;
      @(posedge clk); #1;
      checkOutput("stall_valid", {31'b0, out_valid}, 32'd1);
      checkOutput("stall_data", out_data, edata);
      checkOutput("stall_in_ready", {31'b0, in_ready}, 32'd0);
      checkOutput("stall_mode", {29'b0, fpu_mode}, 32'd7);
      if (legal) checkOutput("stall_rd", {27'b0, out_rd}, {27'b0, ins[11:7]});
    end

    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("wb_valid_drop", {31'b0, out_valid}, 32'd0);
    checkOutput("wb_in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("wb_mode", {29'b0, fpu_mode}, 32'd7);
  endtask

  // Assert reset in the 2nd EXEC cycle of a multiply and make sure nothing leaks out.
  task automatic resetDuringMul();
    in_valid = 1'b1;
    instr    = mkInstr(7'b0001000, 5'd9, 7'b1010011);
    rs1_val  = 32'h40400000;
    rs2_val  = 32'h40800000;
    @(posedge clk); #1;
    in_valid   = 1'b0;
    fpu_result = 32'h41400000;
    checkOutput("rst_pre_mode", {29'b0, fpu_mode}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("rst_mode", {29'b0, fpu_mode}, 32'd7);
    checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rst_out_data", out_data, 32'd0);
    checkOutput("rst_out_exc", {30'b0, out_exc}, 32'd0);
    checkOutput("rst_out_rd", {27'b0, out_rd}, 32'd0);
    checkOutput("rst_fpu_a", fpu_a, 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      checkOutput("rst_no_result", {31'b0, out_valid}, 32'd0);
    end
  endtask

  initial begin
    logic [6:0]  f7;
    logic [31:0] ins;
    int          kind;
    rst          = 1'b1;
    in_valid     = 1'b0;
    instr        = 32'h0;
    rs1_val      = 32'h0;
    rs2_val      = 32'h0;
    fpu_result   = 32'h0;
    fpu_div_flag = 6'd0;
    out_ready    = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset_in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("reset_mode", {29'b0, fpu_mode}, 32'd7);
    checkOutput("reset_a", fpu_a, 32'd0);
    checkOutput("reset_b", fpu_b, 32'd0);
    checkOutput("reset_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("reset_out_rd", {27'b0, out_rd}, 32'd0);
    checkOutput("reset_out_data", out_data, 32'd0);
    checkOutput("reset_out_exc", {30'b0, out_exc}, 32'd0);

    applyStimulus(mkInstr(7'b0000000, 5'd5, 7'b1010011), 32'h3F800000, 32'h40000000, 32'h40400000, 0, 0);
    applyStimulus(mkInstr(7'b0001100, 5'd7, 7'b1010011), 32'h3F800000, 32'h40000000, 32'h3F000000, 20, 0);
    applyStimulus(mkInstr(7'b0001100, 5'd8, 7'b1010011), 32'h40000000, 32'h40400000, 32'h12345678, 0, 0);
    applyStimulus(mkInstr(7'b0001100, 5'd8, 7'b1010011), 32'h40000000, 32'h40400000, 32'h12345678, 1, 0);
    applyStimulus(mkInstr(7'b0001100, 5'd4, 7'b1010011), 32'h40000000, 32'h40400000, 32'h0BADF00D, 64, 1);
    applyStimulus(mkInstr(7'b0010000, 5'd6, 7'b1010011), 32'h1, 32'h2, 32'hDEADBEEF, 0, 0);
    applyStimulus(mkInstr(7'b0000000, 5'd6, 7'b0000011), 32'h1, 32'h2, 32'hDEADBEEF, 0, 0);
    applyStimulus(mkInstr(7'b0001000, 5'd11, 7'b1010011), 32'h40000000, 32'h40400000, 32'h40C00000, 0, 10);

    resetDuringMul();
    applyStimulus(mkInstr(7'b0000100, 5'd12, 7'b1010011), 32'h40400000, 32'h3F800000, 32'h40000000, 0, 0);

    for (int t = 0; t < 30; t++) begin
      kind = $urandom_range(0, 5);
      case (kind)
        0: ins = mkInstr(7'b0000000, 5'($urandom), 7'b1010011);
        1: ins = mkInstr(7'b0000100, 5'($urandom), 7'b1010011);
        2: ins = mkInstr(7'b0001000, 5'($urandom), 7'b1010011);
        3: ins = mkInstr(7'b0001100, 5'($urandom), 7'b1010011);
        4: begin
          f7 = 7'($urandom);
          while (f7 == 7'b0000000 || f7 == 7'b0000100 || f7 == 7'b0001000 || f7 == 7'b0001100)
            f7 = 7'($urandom);
          ins = mkInstr(f7, 5'($urandom), 7'b1010011);
        end
        default: ins = mkInstr(7'b0000000, 5'($urandom), 7'b0110011);
      endcase
      applyStimulus(ins, $urandom, $urandom, $urandom, $urandom_range(1, 70), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
